// File: rtl/counter_if.sv
// Bus bundle for the up/down counter: direction/enable controls in,
// registered count and wrap pulse out.
interface counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             mode;
  logic [WIDTH-1:0] count_out;
  logic             wrap;

  modport master (
    output en,
    output mode,
    input  count_out,
    input  wrap
  );

  modport slave (
    input  en,
    input  mode,
    output count_out,
    output wrap
  );
endinterface

// File: rtl/counter.sv
// Free-running unsigned up/down counter, modulo 2^WIDTH, with a registered
// one-cycle wrap pulse raised on every carry-out or borrow-out step.
module counter #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next;
  logic             wrap_r;
  logic             wrap_next;

  // Next-state: the wrap flag is the discarded carry/borrow of this step.
  always_comb begin
    count_next = count_r;
    wrap_next  = 1'b0;
    case ({bus.en, bus.mode})
      2'b11: begin
        count_next = count_r + ONE;
        wrap_next  = (count_r == ALL_ONES);
      end
      2'b10: begin
        count_next = count_r - ONE;
        wrap_next  = (count_r == ZERO);
      end
      default: begin
        count_next = count_r;
        wrap_next  = 1'b0;
      end
    endcase
  end

  // State registers; reset clears the count and cancels any pending pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= ZERO;
      wrap_r  <= 1'b0;
    end else begin
      count_r <= count_next;
      wrap_r  <= wrap_next;
    end
  end

  assign bus.count_out = count_r;
  assign bus.wrap      = wrap_r;

endmodule

// File: tb/tb_counter.sv
// Directed self-checking bench for the 8-bit counter: reset, up/down runs,
// both wrap directions, direction toggling and asynchronous mid-count reset.
module tb_counter;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  counter_if #(.WIDTH(WIDTH)) bus ();

  counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int exp_count, input logic exp_wrap);
    check_eq({tag, ".count"}, 32'(bus.count_out), 32'(exp_count));
    check_eq({tag, ".wrap"}, 32'(bus.wrap), 32'(exp_wrap));
  endtask

  // Drive inputs just after an edge, take one edge, land 1 time unit past it.
  task automatic step(input logic e, input logic m);
    bus.en   = e;
    bus.mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.mode = 1'b1;

    #1;
    check_out("reset_async", 0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check_out("reset_held", 0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      check_out("idle_hold", 0, 1'b0);
    end

    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1);
      check_out("up_run", i, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      check_out("en_off_hold", 10, 1'b0);
    end

    pulse_reset();
    check_out("reset_to_zero", 0, 1'b0);
    step(1'b1, 1'b0);
    check_out("down_wrap", 255, 1'b1);
    step(1'b1, 1'b0);
    check_out("down_254", 254, 1'b0);
    step(1'b1, 1'b0);
    check_out("down_253", 253, 1'b0);
    for (int i = 252; i >= 250; i--) begin
      step(1'b1, 1'b0);
      check_out("down_to_250", i, 1'b0);
    end

    for (int i = 251; i <= 255; i++) begin
      step(1'b1, 1'b1);
      check_out("up_to_max", i, 1'b0);
    end
    step(1'b1, 1'b1);
    check_out("up_wrap", 0, 1'b1);
    step(1'b0, 1'b1);
    check_out("wrap_cleared_by_idle", 0, 1'b0);

    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b1);
    end
    check_out("at_5", 5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
      check_out("toggle", (i % 2 == 0) ? 6 : 5, 1'b0);
    end

    pulse_reset();
    for (int i = 1; i <= 37; i++) begin
      step(1'b1, 1'b1);
    end
    check_out("at_37", 37, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("async_mid_count", 0, 1'b0);
    step(1'b1, 1'b1);
    check_out("reset_blocks_count", 0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b1);
    check_out("resume_1", 1, 1'b0);
    step(1'b1, 1'b1);
    check_out("resume_2", 2, 1'b0);

    pulse_reset();
    step(1'b1, 1'b0);
    check_out("pre_cancel_wrap", 255, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("reset_cancels_wrap", 0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b1);
    check_out("after_cancel", 1, 1'b0);

    pulse_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check_out("dir_change_to_0", 0, 1'b0);
    step(1'b1, 1'b0);
    check_out("dir_change_wrap", 255, 1'b1);
    step(1'b1, 1'b1);
    check_out("dir_change_back_wrap", 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
